// File: rtl/sat_accumulator_widen.sv
// Widening saturating accumulator: sums narrow signed samples per i_last-delimited frame.
// Optional macro SATACC_SCALED_OUT_EN divides the emitted sum by 2^SHIFT, rounding toward zero.
module sat_accumulator_widen #(
  parameter int INW   = 8,
  parameter int ACCW  = 16,
  parameter int CNTW  = 8,
  parameter int SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic signed [INW-1:0]  i_sample,
  input  logic                   i_last,
  input  logic                   i_clear,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic signed [ACCW-1:0] o_sum,
  output logic [CNTW-1:0]        o_count,
  output logic                   o_satPos,
  output logic                   o_satNeg
);

  if (ACCW <= INW || SHIFT < 0 || SHIFT >= ACCW) begin : g_param_check
    $error("sat_accumulator_widen: need ACCW > INW and 0 <= SHIFT < ACCW");
  end

  typedef enum logic {S_ACCUM, S_HOLD} state_t;

  localparam logic signed [ACCW:0] MAX_W = {2'b00, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW:0] MIN_W = {2'b11, {(ACCW-1){1'b0}}};

  state_t                 state, state_nxt;
  logic signed [ACCW-1:0] acc, acc_upd, sum_out;
  logic signed [ACCW:0]   sum_wide;
  logic [CNTW-1:0]        cnt, cnt_upd;
  logic                   sat_pos, sat_neg, pos_upd, neg_upd;
  logic                   accept;

  // Ready is masked by rst so no upstream sample is ever seen as accepted during reset.
  assign o_ready = (state == S_ACCUM) && !rst;
  assign o_valid = (state == S_HOLD);
  assign accept  = i_valid && o_ready && !i_clear;

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sum_wide = {acc[ACCW-1], acc} + {{(ACCW+1-INW){i_sample[INW-1]}}, i_sample};
    acc_upd  = sum_wide[ACCW-1:0];
    pos_upd  = sat_pos;
    neg_upd  = sat_neg;
    if (sum_wide > MAX_W) begin
      acc_upd = MAX_W[ACCW-1:0];
      pos_upd = 1'b1;
    end else if (sum_wide < MIN_W) begin
      acc_upd = MIN_W[ACCW-1:0];
      neg_upd = 1'b1;
    end
    cnt_upd = (cnt == '1) ? cnt : cnt + 1'b1;
  end

`ifdef SATACC_SCALED_OUT_EN
  // Bias negatives by 2^SHIFT-1 so the arithmetic shift truncates toward zero.
  always_comb begin
    if (acc_upd[ACCW-1]) sum_out = (acc_upd + ACCW'((1 << SHIFT) - 1)) >>> SHIFT;
    else                 sum_out = acc_upd >>> SHIFT;
  end
`else
  assign sum_out = acc_upd;
`endif

  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = S_ACCUM;
    end else begin
      case (state)
        S_ACCUM: if (accept && i_last) state_nxt = S_HOLD;
        S_HOLD:  if (i_ready)          state_nxt = S_ACCUM;
        default:                       state_nxt = S_ACCUM;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_ACCUM;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      sat_pos  <= 1'b0;
      sat_neg  <= 1'b0;
      o_sum    <= '0;
      o_count  <= '0;
      o_satPos <= 1'b0;
      o_satNeg <= 1'b0;
    end else if (i_clear) begin
      acc     <= '0;
      cnt     <= '0;
      sat_pos <= 1'b0;
      sat_neg <= 1'b0;
    end else if (accept) begin
      if (i_last) begin
        o_sum    <= sum_out;
        o_count  <= cnt_upd;
        o_satPos <= pos_upd;
        o_satNeg <= neg_upd;
        acc      <= '0;
        cnt      <= '0;
        sat_pos  <= 1'b0;
        sat_neg  <= 1'b0;
      end else begin
        acc     <= acc_upd;
        cnt     <= cnt_upd;
        sat_pos <= pos_upd;
        sat_neg <= neg_upd;
      end
    end
  end

endmodule

// File: tb/tb_sat_accumulator_widen.sv
// Directed bench for sat_accumulator_widen; expected sums follow SATACC_SCALED_OUT_EN when defined.
module tb_sat_accumulator_widen;

  localparam int INW  = 8;
  localparam int ACCW = 16;
  localparam int CNTW = 8;
`ifdef SATACC_SCALED_OUT_EN
  localparam int SHIFT = 2;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   i_valid = 1'b0;
  logic                   o_ready;
  logic signed [INW-1:0]  i_sample = '0;
  logic                   i_last = 1'b0;
  logic                   i_clear = 1'b0;
  logic                   o_valid;
  logic                   i_ready = 1'b0;
  logic signed [ACCW-1:0] o_sum;
  logic [CNTW-1:0]        o_count;
  logic                   o_satPos;
  logic                   o_satNeg;

  int checks   = 0;
  int failures = 0;

  sat_accumulator_widen #(.INW(INW), .ACCW(ACCW), .CNTW(CNTW), .SHIFT(2)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_sample(i_sample),
    .i_last(i_last), .i_clear(i_clear), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_count(o_count), .o_satPos(o_satPos), .o_satNeg(o_satNeg)
  );

  always #5 clk = ~clk;

  // Emitted sum for a given saturated raw sum; int division truncates toward zero.
  function automatic logic signed [ACCW-1:0] exp_sum(input int raw);
`ifdef SATACC_SCALED_OUT_EN
    return ACCW'(raw / (1 << SHIFT));
`else
    return ACCW'(raw);
`endif
  endfunction

  function automatic logic [ACCW+CNTW+2:0] res_now();
    return {o_valid, o_sum, o_count, o_satPos, o_satNeg};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic last);
    int n;
    n = 0;
    i_valid  = 1'b1;
    i_sample = INW'(s);
    i_last   = last;
    while (!o_ready && n < 20) begin
      cycle();
      n++;
    end
    if (!o_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout o_ready=%b required=1", o_ready);
    end
    cycle();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic consume(input string name);
    i_ready = 1'b1;
    cycle();
    i_ready = 1'b0;
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      failures++;
      $display("FAIL %s_consume valid,ready=%b required=01", name, {o_valid, o_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      cycle();
      checks++;
      if (o_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready o_ready=%b required=0", o_ready);
      end
    end
    checks++;
    if (res_now() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", res_now());
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_valid} !== 2'b10) begin
      failures++;
      $display("FAIL post_reset ready,valid=%b required=10", {o_ready, o_valid});
    end
  endtask

  task automatic test_basic();
    logic [ACCW+CNTW+2:0] want;
    i_ready = 1'b1;
    send(10, 1'b0);
    send(-3, 1'b0);
    send(5, 1'b1);
    want = {1'b1, exp_sum(12), 8'd3, 1'b0, 1'b0};
    checks++;
    if (res_now() !== want || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got=%h ready=%b required=%h ready=0", res_now(), o_ready, want);
    end
    cycle();
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      failures++;
      $display("FAIL basic_one_cycle valid,ready=%b required=01", {o_valid, o_ready});
    end
    i_ready = 1'b0;
  endtask

  task automatic test_pos_sat();
    logic [ACCW+CNTW+2:0] want;
    for (int i = 0; i < 300; i++) send(127, i == 299);
    want = {1'b1, exp_sum(32767), 8'd255, 1'b1, 1'b0};
    checks++;
    if (res_now() !== want) begin
      failures++;
      $display("FAIL pos_sat got=%h required=%h", res_now(), want);
    end
    consume("pos_sat");
    // Clamp at 32767 after sample 259, then -100 keeps accumulating from the rail.
    for (int i = 0; i < 259; i++) send(127, 1'b0);
    send(-100, 1'b1);
    want = {1'b1, exp_sum(32667), 8'd255, 1'b1, 1'b0};
    checks++;
    if (res_now() !== want) begin
      failures++;
      $display("FAIL pos_sat_continue got=%h required=%h", res_now(), want);
    end
    consume("pos_sat_continue");
  endtask

  task automatic test_neg_boundary();
    logic [ACCW+CNTW+2:0] want;
    for (int i = 0; i < 256; i++) send(-128, i == 255);
    want = {1'b1, exp_sum(-32768), 8'd255, 1'b0, 1'b0};
    checks++;
    if (res_now() !== want) begin
      failures++;
      $display("FAIL neg_exact got=%h required=%h", res_now(), want);
    end
    consume("neg_exact");
    for (int i = 0; i < 257; i++) send(-128, i == 256);
    want = {1'b1, exp_sum(-32768), 8'd255, 1'b0, 1'b1};
    checks++;
    if (res_now() !== want) begin
      failures++;
      $display("FAIL neg_sat got=%h required=%h", res_now(), want);
    end
    consume("neg_sat");
  endtask

  task automatic test_backpressure_clear();
    logic [ACCW+CNTW+2:0] want;
    send(1, 1'b0);
    send(2, 1'b1);
    want = {1'b1, exp_sum(3), 8'd2, 1'b0, 1'b0};
    i_valid  = 1'b1;
    i_sample = INW'(99);
    i_last   = 1'b1;
    repeat (5) begin
      checks++;
      if (res_now() !== want || o_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable got=%h ready=%b required=%h ready=0", res_now(), o_ready, want);
      end
      cycle();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    consume("hold");

    send(50, 1'b0);
    send(50, 1'b0);
    i_clear  = 1'b1;
    i_valid  = 1'b1;
    i_sample = INW'(100);
    i_last   = 1'b1;
    cycle();
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      failures++;
      $display("FAIL clear_drops_last valid,ready=%b required=01", {o_valid, o_ready});
    end
    send(7, 1'b1);
    want = {1'b1, exp_sum(7), 8'd1, 1'b0, 1'b0};
    checks++;
    if (res_now() !== want) begin
      failures++;
      $display("FAIL after_clear got=%h required=%h", res_now(), want);
    end
    consume("after_clear");

    send(4, 1'b1);
    i_clear = 1'b1;
    cycle();
    i_clear = 1'b0;
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      failures++;
      $display("FAIL clear_in_hold valid,ready=%b required=01", {o_valid, o_ready});
    end
    send(3, 1'b1);
    want = {1'b1, exp_sum(3), 8'd1, 1'b0, 1'b0};
    checks++;
    if (res_now() !== want) begin
      failures++;
      $display("FAIL after_hold_clear got=%h required=%h", res_now(), want);
    end
    consume("after_hold_clear");
  endtask

  task automatic test_scaling();
    int vals [3] = '{-7, 7, -8};
    logic [ACCW+CNTW+2:0] want;
    foreach (vals[k]) begin
      send(vals[k], 1'b1);
      want = {1'b1, exp_sum(vals[k]), 8'd1, 1'b0, 1'b0};
      checks++;
      if (res_now() !== want) begin
        failures++;
        $display("FAIL scale_%0d got=%h required=%h", vals[k], res_now(), want);
      end
      consume("scale");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_boundary();
    test_backpressure_clear();
    test_scaling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sat_accumulator_widen.md
Name: sat_accumulator_widen

Overview:
- Streaming reader-side counterpart to the team's saturation/clamp library.
- Consumes narrow signed samples, which are typically the output of a range clamp, over a valid/ready handshake.
- Widens and accumulates them into a saturating wide signed sum, tracking sticky overflow flags.
- Emits one result per frame, delimited by i_last, on a second valid/ready handshake. Sits between narrowing/clamp stages and wider downstream arithmetic (e.g. block energy/mean computation).

Parameters:
- INW, 8, input sample width (signed two's complement).
- ACCW, 16, accumulator/output width (signed); must satisfy ACCW > INW.
- CNTW, 8, sample counter width.
- SHIFT, 2, right-shift amount applied only when SATACC_SCALED_OUT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept a sample.
- i_sample  in  INW  signed input sample.
- i_last  in  1  qualifies the accepted sample as the final one of a frame.
- i_clear  in  1  synchronous abort: discards the current frame.
- o_valid  out  1  frame result valid.
- i_ready  in  1  downstream accepts the result.
- o_sum  out  ACCW  signed saturated frame sum (scaled if macro defined).
- o_count  out  CNTW  number of samples in the frame, saturating at 2^CNTW-1.
- o_satPos  out  1  sticky: positive clamp occurred in this frame.
- o_satNeg  out  1  sticky: negative clamp occurred in this frame.

Behaviour:
- Reset, with rst=1 sampled at an edge:
  - State goes to ACCUM.
  - Accumulator, o_sum, o_count, o_satPos, o_satNeg and o_valid are all 0.
  - o_ready is 0 during reset and 1 from the first cycle after rst deasserts.
  - Reset mid-frame or mid-HOLD discards everything.
- An input sample is accepted when i_valid & o_ready at an edge.
- States:
  - ACCUM: o_ready=1, o_valid=0.
  - HOLD: o_ready=0, o_valid=1.
- ACCUM, sample accepted:
  - next = acc + sign_extend(i_sample), computed at ACCW+1 bits.
  - If next > 2^(ACCW-1)-1, acc becomes 2^(ACCW-1)-1 and satPos is set.
  - If next < -2^(ACCW-1), acc becomes -2^(ACCW-1) and satNeg is set.
  - Otherwise acc becomes next.
  - count increments, holding at 2^CNTW-1 with no wrap.
  - If i_last=1 on the accepted sample: o_sum, o_count and flags are loaded from the updated values in the same edge. The state goes to HOLD, so o_valid is asserted the cycle after the last sample is accepted (latency 1).
  - The internal acc, count and flags are reset to 0 for the next frame.
- ACCUM, no sample accepted: nothing changes.
- HOLD:
  - o_sum, o_count and flags are stable while i_ready=0.
  - On i_ready=1, the state goes to ACCUM, o_valid drops and o_ready rises the next cycle.
  - No input is accepted in the cycle the result is consumed.
- i_clear=1 (highest priority after rst):
  - The internal acc, count and flags go to 0 and the state goes to ACCUM.
  - If in HOLD, the pending result is dropped (o_valid goes to 0).
  - A sample presented in the same cycle is not accepted (it is dropped), even with i_last.
  - o_sum, o_count and the output flags keep their last values but are meaningless while o_valid=0.
- Frame boundaries:
  - A one-sample frame (i_last on the first sample) is legal.
  - A zero-sample frame cannot occur.
- Flags clamp but accumulation continues. For example, after positive saturation a negative sample subtracts from the clamped max value; there is no latching at the rail.

Optional Feature:
- Macro: SATACC_SCALED_OUT_EN.
- Defined: o_sum = saturated sum divided by 2^SHIFT, rounding toward zero.
  - Negative sums add 2^SHIFT-1 before the arithmetic shift.
  - Computed combinationally from the internal sum before the HOLD register load; latency unchanged.
  - Flags and count are unaffected.
- Undefined: o_sum is the raw saturated sum and SHIFT is ignored.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release -> o_valid=0, o_sum=0, o_count=0, flags 0; o_ready=0 during reset and 1 on the first post-reset cycle.
- Basic frame: samples 10, -3, 5 (i_last on 5), i_ready=1 -> o_valid=1 the cycle after 5 is accepted, o_sum=12, o_count=3, flags 0; o_valid lasts 1 cycle; o_ready=0 only in that cycle.
- Positive saturation: 300 samples of 127, i_last on the 300th -> o_sum=32767, o_satPos=1, o_satNeg=0, o_count=255.
- Negative boundary: 256 samples of -128 -> o_sum=-32768, o_satNeg=0. Repeat with 257 samples -> o_sum=-32768, o_satNeg=1.
- Backpressure and clear:
  - Result pending with i_ready=0 for 5 cycles while i_valid=1 -> o_ready=0, outputs stable, no sample accepted.
  - Then i_ready=1 -> o_valid=0 next cycle.
  - Then samples 50, 50, i_clear pulse, then 7 with i_last -> o_sum=7, o_count=1.
- Macro defined, SHIFT=2:
  - Frame -7 -> o_sum=-1.
  - Frame 7 -> o_sum=1.
  - Frame -8 -> o_sum=-2.
  - Macro undefined, same frames -> -7, 7, -8.
